// File: rtl/vscale_imm_issue_ctrl_pkg.sv
// Shared constants for the immediate issue controller: immediate format codes,
// RV32 major opcodes and the queue occupancy states.
package vscale_imm_issue_ctrl_pkg;

   localparam int IMM_TYPE_WIDTH = 2;

   localparam logic [IMM_TYPE_WIDTH-1:0] IMM_I = 2'd0;
   localparam logic [IMM_TYPE_WIDTH-1:0] IMM_S = 2'd1;
   localparam logic [IMM_TYPE_WIDTH-1:0] IMM_U = 2'd2;
   localparam logic [IMM_TYPE_WIDTH-1:0] IMM_J = 2'd3;

   localparam logic [6:0] RV32_LOAD     = 7'b0000011;
   localparam logic [6:0] RV32_STORE    = 7'b0100011;
   localparam logic [6:0] RV32_OP_IMM   = 7'b0010011;
   localparam logic [6:0] RV32_LUI      = 7'b0110111;
   localparam logic [6:0] RV32_AUIPC    = 7'b0010111;
   localparam logic [6:0] RV32_JAL      = 7'b1101111;
   localparam logic [6:0] RV32_JALR     = 7'b1100111;
   localparam logic [6:0] RV32_SYSTEM   = 7'b1110011;
   localparam logic [6:0] RV32_OP       = 7'b0110011;
   localparam logic [6:0] RV32_BRANCH   = 7'b1100011;
   localparam logic [6:0] RV32_MISC_MEM = 7'b0001111;

   typedef enum logic [1:0] {
      Q_EMPTY,
      Q_PARTIAL,
      Q_FULL
   } q_state_e;

endpackage

// File: rtl/vscale_imm_gen.sv
// Immediate generator: extracts and sign-extends the immediate of an RV32
// instruction for the requested format.
module vscale_imm_gen
   import vscale_imm_issue_ctrl_pkg::*;
#(
   parameter int XPR_LEN = 32
) (
   input  logic [XPR_LEN-1:0]        inst,
   input  logic [IMM_TYPE_WIDTH-1:0] imm_type,
   output logic [XPR_LEN-1:0]        imm
);

   always_comb begin
      imm = '0;
      case (imm_type)
         IMM_I: imm = {{(XPR_LEN-11){inst[31]}}, inst[30:20]};
         IMM_S: imm = {{(XPR_LEN-11){inst[31]}}, inst[30:25], inst[11:7]};
         IMM_U: imm = {{(XPR_LEN-31){inst[31]}}, inst[30:12], 12'b0};
         IMM_J: imm = {{(XPR_LEN-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
         default: imm = '0;
      endcase
   end

endmodule

// File: rtl/vscale_imm_issue_ctrl_type_dec.sv
// Opcode decoder: picks the immediate format, whether the instruction uses
// an immediate at all, and flags opcodes outside the supported set.
module vscale_imm_type_dec
   import vscale_imm_issue_ctrl_pkg::*;
(
   input  logic [6:0]                opcode,
   output logic [IMM_TYPE_WIDTH-1:0] imm_type,
   output logic                      imm_used,
   output logic                      illegal
);

   always_comb begin
      imm_type = IMM_I;
      imm_used = 1'b0;
      illegal  = 1'b0;
      case (opcode)
         RV32_LOAD, RV32_OP_IMM, RV32_JALR, RV32_SYSTEM: imm_used = 1'b1;
         RV32_STORE: begin
            imm_type = IMM_S;
            imm_used = 1'b1;
         end
         RV32_LUI, RV32_AUIPC: begin
            imm_type = IMM_U;
            imm_used = 1'b1;
         end
         RV32_JAL: begin
            imm_type = IMM_J;
            imm_used = 1'b1;
         end
         RV32_OP, RV32_BRANCH, RV32_MISC_MEM: imm_used = 1'b0;
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/vscale_imm_issue_ctrl.sv
// Decode-side issue controller: small FIFO of fetched instructions feeding a
// single registered valid/ready stage with decoded immediate information.
module vscale_imm_issue_ctrl
   import vscale_imm_issue_ctrl_pkg::*;
#(
   parameter int XPR_LEN = 32,
   parameter int DEPTH   = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      kill,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [XPR_LEN-1:0]        in_inst,
   input  logic [XPR_LEN-1:0]        in_pc,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [XPR_LEN-1:0]        out_inst,
   output logic [XPR_LEN-1:0]        out_pc,
   output logic [XPR_LEN-1:0]        out_imm,
   output logic [IMM_TYPE_WIDTH-1:0] out_imm_type,
   output logic                      out_imm_used,
   output logic                      out_illegal
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [XPR_LEN-1:0] q_inst [DEPTH];
   logic [XPR_LEN-1:0] q_pc   [DEPTH];

   q_state_e           q_state, q_state_next;
   logic [CNT_W-1:0]   count, count_next;
   logic [PTR_W-1:0]   rd_ptr, rd_next, wr_ptr, wr_next;

   logic accept, load_en, have_head, have_src, load, bypass, enq, deq;

   logic [XPR_LEN-1:0]        sel_inst, sel_pc, sel_imm;
   logic [IMM_TYPE_WIDTH-1:0] sel_type;
   logic                      sel_used, sel_illegal;

   assign in_ready = (q_state != Q_FULL);

   always_comb begin
      have_head = (q_state != Q_EMPTY);
      accept    = in_valid && in_ready && !kill;
      load_en   = !out_valid || out_ready;
      have_src  = have_head || accept;
      load      = !kill && load_en && have_src;
      // Bypass only when nothing is queued, so FIFO order is never violated.
      bypass    = load && !have_head;
      deq       = load && have_head;
      enq       = accept && !bypass;
      sel_inst  = have_head ? q_inst[rd_ptr] : in_inst;
      sel_pc    = have_head ? q_pc[rd_ptr]   : in_pc;
   end

   always_comb begin
      count_next = count;
      rd_next    = rd_ptr;
      wr_next    = wr_ptr;
      if (kill) begin
         count_next = '0;
         rd_next    = '0;
         wr_next    = '0;
      end else begin
         if (enq) wr_next = wr_ptr + 1'b1;
         if (deq) rd_next = rd_ptr + 1'b1;
         case ({enq, deq})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
         endcase
      end
      if (count_next == '0)
         q_state_next = Q_EMPTY;
      else if (count_next == CNT_W'(DEPTH))
         q_state_next = Q_FULL;
      else
         q_state_next = Q_PARTIAL;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_state <= Q_EMPTY;
         count   <= '0;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
      end else begin
         q_state <= q_state_next;
         count   <= count_next;
         rd_ptr  <= rd_next;
         wr_ptr  <= wr_next;
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         q_inst[wr_ptr] <= in_inst;
         q_pc[wr_ptr]   <= in_pc;
      end
   end

   vscale_imm_type_dec u_type_dec (
      .opcode   (sel_inst[6:0]),
      .imm_type (sel_type),
      .imm_used (sel_used),
      .illegal  (sel_illegal)
   );

   vscale_imm_gen #(.XPR_LEN(XPR_LEN)) u_imm_gen (
      .inst     (sel_inst),
      .imm_type (sel_type),
      .imm      (sel_imm)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid    <= 1'b0;
         out_inst     <= '0;
         out_pc       <= '0;
         out_imm      <= '0;
         out_imm_type <= IMM_I;
         out_imm_used <= 1'b0;
         out_illegal  <= 1'b0;
      end else if (kill) begin
         out_valid <= 1'b0;
      end else if (load_en) begin
         out_valid <= have_src;
         if (have_src) begin
            out_inst     <= sel_inst;
            out_pc       <= sel_pc;
            out_imm      <= sel_imm;
            out_imm_type <= sel_type;
            out_imm_used <= sel_used;
            out_illegal  <= sel_illegal;
         end
      end
   end

endmodule

// File: tb/tb_vscale_imm_issue_ctrl.sv
// Scoreboard bench for vscale_imm_issue_ctrl: the driver queues hand-computed
// expectations on each accept, the monitor checks every presented output.
module tb_vscale_imm_issue_ctrl;
   import vscale_imm_issue_ctrl_pkg::*;

   logic                      clk = 1'b0;
   logic                      reset, kill, in_valid, in_ready, out_valid, out_ready;
   logic [31:0]               in_inst, in_pc, out_inst, out_pc, out_imm;
   logic [IMM_TYPE_WIDTH-1:0] out_imm_type;
   logic                      out_imm_used, out_illegal;

   typedef struct {
      logic [31:0]               inst;
      logic [31:0]               pc;
      logic [31:0]               imm;
      logic [IMM_TYPE_WIDTH-1:0] typ;
      logic                      used;
      logic                      ill;
   } item_t;

   item_t       sb[$];
   int          tests = 0;
   int          fails = 0;
   logic [31:0] pc_ctr = 32'h0000_1000;
   int          w;

   vscale_imm_issue_ctrl #(.XPR_LEN(32), .DEPTH(2)) dut (
      .clk          (clk),
      .reset        (reset),
      .kill         (kill),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_inst      (in_inst),
      .in_pc        (in_pc),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_inst     (out_inst),
      .out_pc       (out_pc),
      .out_imm      (out_imm),
      .out_imm_type (out_imm_type),
      .out_imm_used (out_imm_used),
      .out_illegal  (out_illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic send(input logic [31:0] inst, input logic [31:0] imm,
                       input logic [IMM_TYPE_WIDTH-1:0] typ, input logic used,
                       input logic ill, output int waited);
      item_t it;
      logic  ok;
      logic  done;
      it.inst = inst;  it.pc = pc_ctr;  it.imm = imm;
      it.typ  = typ;   it.used = used;  it.ill = ill;
      pc_ctr  = pc_ctr + 32'd4;
      in_valid = 1'b1;
      in_inst  = inst;
      in_pc    = it.pc;
      waited   = 0;
      done     = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         ok = in_ready && !kill;
         @(posedge clk);
         #1;
         if (ok) begin
            sb.push_back(it);
            done = 1'b1;
         end else begin
            waited++;
         end
      end
      in_valid = 1'b0;
      tests++;
      if (!done) begin
         fails++;
         $display("FAIL accept_timeout: inst 0x%08h not accepted within 40 cycles", inst);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 30 && sb.size() != 0; i++) idle(1);
      check(name, 32'(sb.size()), 32'd0);
   endtask

   always @(negedge clk) begin
      if (!reset && out_valid) begin
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL out_unexpected: got inst 0x%08h with nothing expected", out_inst);
         end else begin
            if (out_inst !== sb[0].inst || out_pc !== sb[0].pc || out_imm !== sb[0].imm ||
                out_imm_type !== sb[0].typ || out_imm_used !== sb[0].used ||
                out_illegal !== sb[0].ill) begin
               fails++;
               $display("FAIL out_data: got inst=%08h pc=%08h imm=%08h type=%0d used=%b ill=%b expected inst=%08h pc=%08h imm=%08h type=%0d used=%b ill=%b",
                        out_inst, out_pc, out_imm, out_imm_type, out_imm_used, out_illegal,
                        sb[0].inst, sb[0].pc, sb[0].imm, sb[0].typ, sb[0].used, sb[0].ill);
            end
            if (out_ready) void'(sb.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;  kill = 1'b0;  in_valid = 1'b0;  out_ready = 1'b0;
      in_inst = '0;  in_pc = '0;
      idle(3);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_imm", out_imm, 32'd0);
      check("rst_out_inst", out_inst, 32'd0);
      check("rst_imm_type", 32'(out_imm_type), 32'(IMM_I));
      @(negedge clk) reset = 1'b0;
      idle(1);

      // empty queue, latency 1
      out_ready = 1'b1;
      send(32'hFFF00093, 32'hFFFFFFFF, IMM_I, 1'b1, 1'b0, w);
      check("lat1_out_valid", 32'(out_valid), 32'd1);
      idle(2);

      // back-to-back stream
      send(32'h123452B7, 32'h12345000, IMM_U, 1'b1, 1'b0, w);
      check("b2b_wait0", 32'(w), 32'd0);
      send(32'h0020A423, 32'h00000008, IMM_S, 1'b1, 1'b0, w);
      check("b2b_wait1", 32'(w), 32'd0);
      send(32'hFFDFF06F, 32'hFFFFFFFC, IMM_J, 1'b1, 1'b0, w);
      check("b2b_wait2", 32'(w), 32'd0);
      check("b2b_in_ready", 32'(in_ready), 32'd1);
      wait_drain("b2b_drained");

      // illegal flagging
      send(32'h00000000, 32'h00000000, IMM_I, 1'b0, 1'b1, w);
      send(32'h00000033, 32'h00000000, IMM_I, 1'b0, 1'b0, w);
      wait_drain("illegal_drained");

      // back-pressure: 1 in output + 2 queued, 4th waits
      out_ready = 1'b0;
      send(32'h00400513, 32'h00000004, IMM_I, 1'b1, 1'b0, w);
      send(32'h00001117, 32'h00001000, IMM_U, 1'b1, 1'b0, w);
      check("hold_in_ready_partial", 32'(in_ready), 32'd1);
      send(32'hFE000EE3, 32'hFFFFFFE0, IMM_I, 1'b0, 1'b0, w);
      check("hold_in_ready_full", 32'(in_ready), 32'd0);
      idle(3);
      fork
         send(32'h0000000F, 32'h00000000, IMM_I, 1'b0, 1'b0, w);
         begin
            idle(2);
            out_ready = 1'b1;
         end
      join
      wait_drain("hold_drained");

      // kill while full with a same-cycle input
      out_ready = 1'b0;
      send(32'h00000073, 32'h00000000, IMM_I, 1'b1, 1'b0, w);
      send(32'hFFC42683, 32'hFFFFFFFC, IMM_I, 1'b1, 1'b0, w);
      send(32'h00400513, 32'h00000004, IMM_I, 1'b1, 1'b0, w);
      in_valid = 1'b1;  in_inst = 32'h7FF00093;  in_pc = 32'hDEAD0000;  kill = 1'b1;
      @(posedge clk);
      #1;
      kill = 1'b0;  in_valid = 1'b0;
      sb.delete();
      check("kill_out_valid", 32'(out_valid), 32'd0);
      check("kill_in_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      idle(3);
      send(32'hFFC42683, 32'hFFFFFFFC, IMM_I, 1'b1, 1'b0, w);
      check("kill_fresh_lat1", 32'(out_valid), 32'd1);
      wait_drain("kill_drained");

      // asynchronous reset mid-stream
      out_ready = 1'b0;
      send(32'h00400513, 32'h00000004, IMM_I, 1'b1, 1'b0, w);
      send(32'h00001117, 32'h00001000, IMM_U, 1'b1, 1'b0, w);
      check("pre_rst_out_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
      #2;
      reset = 1'b1;
      sb.delete();
      #1;
      check("async_rst_out_valid", 32'(out_valid), 32'd0);
      check("async_rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk) reset = 1'b0;
      out_ready = 1'b1;
      idle(1);
      send(32'h0020A423, 32'h00000008, IMM_S, 1'b1, 1'b0, w);
      check("post_rst_lat1", 32'(out_valid), 32'd1);
      wait_drain("final_drained");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
